// File: rtl/rv32_pkg.sv
// Shared RV32 front-end types: word geometry and the fetch-queue entry.
// Address alignment in fetch is controlled by the FETCH_ALIGN_EN macro.
package rv32_pkg;

    localparam int XLEN       = 32;
    localparam int DATA_BYTES = XLEN / 8;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] data;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc,data} queue between the memory return path and the decoder.
// Flush empties it in one edge; push and pop may coincide.
module fetch_fifo
    import rv32_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);

    fetch_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (flush) begin
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch.sv
// Instruction fetch: PC, one in-flight memory read and a 2-entry output queue.
// Define FETCH_ALIGN_EN to force redirect/reset addresses to word alignment.
module fetch
    import rv32_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 9,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_data,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_addr,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_pc
);

`ifdef FETCH_ALIGN_EN
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(DATA_BYTES - 1);
`else
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = '1;
`endif
    localparam logic [ADDR_WIDTH-1:0] START_ADDR = RESET_ADDR & ALIGN_MASK;
    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(DATA_BYTES);

    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic                  inflight;
    logic [1:0]            count;
    logic [2:0]            occ;
    logic                  pop;
    logic                  push;
    logic                  issue;
    fetch_entry_t          din;
    fetch_entry_t          head;
    logic                  unused_bits;

    assign imem_addr = redirect ? (redirect_addr & ALIGN_MASK) : pc;

    assign inst_valid = (count != 2'd0);
    assign pop        = inst_valid & inst_ready;
    assign push       = inflight & ~redirect;

    // Slots already committed (queued + in flight) after this cycle's pop.
    assign occ   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign issue = redirect | (occ < 3'd2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= START_ADDR;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= imem_addr + STEP;
                inflight_pc <= imem_addr;
            end
        end
    end

    assign din.pc   = XLEN'(inflight_pc);
    assign din.data = XLEN'(imem_data);

    fetch_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .din   (din),
        .count (count),
        .head  (head)
    );

    assign inst_data   = inst_valid ? head.data[DATA_WIDTH-1:0] : '0;
    assign inst_pc     = inst_valid ? head.pc[ADDR_WIDTH-1:0] : '0;
    assign unused_bits = ^{head.pc, head.data};

endmodule

// File: tb/tb_fetch.sv
// Directed bench for fetch: latency, stall, redirect, wrap, alignment, reset.
// Memory model returns 0x13 + byte address one cycle after the address.
module tb_fetch;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_data;
    logic          redirect;
    logic [AW-1:0] redirect_addr;
    logic          inst_valid;
    logic          inst_ready;
    logic [DW-1:0] inst_data;
    logic [AW-1:0] inst_pc;

    int total = 0;
    int bad   = 0;

`ifdef FETCH_ALIGN_EN
    localparam logic [AW-1:0] ODD_PC = 9'h040;
`else
    localparam logic [AW-1:0] ODD_PC = 9'h043;
`endif

    fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_ADDR (9'h000)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc)
    );

    always #5 clk = ~clk;

    always @(posedge clk) imem_data <= 32'h13 + 32'(imem_addr);

    function automatic logic [31:0] word(input logic [AW-1:0] a);
        return 32'h13 + 32'(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic inst(input string tag, input logic [AW-1:0] pc);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
        chk({tag, "_pc"}, 32'(inst_pc), 32'(pc));
        chk({tag, "_data"}, inst_data, word(pc));
    endtask

    initial begin
        rst           = 1'b1;
        redirect      = 1'b0;
        redirect_addr = '0;
        inst_ready    = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_data", inst_data, 32'd0);
        chk("rst_pc", 32'(inst_pc), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);

        rst = 1'b0;
        @(negedge clk);
        chk("lat1_valid", 32'(inst_valid), 32'd0);
        @(negedge clk); inst("s0", 9'h000);
        @(negedge clk); inst("s1", 9'h004);
        @(negedge clk); inst("s2", 9'h008);

        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            inst("hold", 9'h008);
            chk("hold_cnt", 32'(dut.u_fifo.count <= 2'd2), 32'd1);
        end
        inst_ready = 1'b1;
        @(negedge clk); inst("res0", 9'h00c);
        @(negedge clk); inst("res1", 9'h010);
        @(negedge clk); inst("res2", 9'h014);

        inst_ready = 1'b0;
        @(negedge clk);
        chk("full_cnt", 32'(dut.u_fifo.count), 32'd2);
        redirect      = 1'b1;
        redirect_addr = 9'h040;
        @(negedge clk);
        chk("rd_flush", 32'(inst_valid), 32'd0);
        redirect   = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk); inst("rd0", 9'h040);
        @(negedge clk); inst("rd1", 9'h044);

        redirect      = 1'b1;
        redirect_addr = 9'h080;
        @(negedge clk);
        chk("bb_v0", 32'(inst_valid), 32'd0);
        redirect_addr = 9'h0a0;
        @(negedge clk);
        chk("bb_v1", 32'(inst_valid), 32'd0);
        redirect = 1'b0;
        @(negedge clk); inst("bb0", 9'h0a0);
        @(negedge clk); inst("bb1", 9'h0a4);

        redirect      = 1'b1;
        redirect_addr = 9'h1f8;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk); inst("wr0", 9'h1f8);
        @(negedge clk); inst("wr1", 9'h1fc);
        @(negedge clk); inst("wr2", 9'h000);
        @(negedge clk); inst("wr3", 9'h004);

        redirect      = 1'b1;
        redirect_addr = 9'h043;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk); inst("al0", ODD_PC);
        @(negedge clk); inst("al1", ODD_PC + 9'd4);

        rst = 1'b1;
        #1;
        chk("mr_valid", 32'(inst_valid), 32'd0);
        chk("mr_pc", 32'(inst_pc), 32'd0);
        chk("mr_data", inst_data, 32'd0);
        @(negedge clk);
        chk("mr_addr", 32'(imem_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_lat", 32'(inst_valid), 32'd0);
        @(negedge clk); inst("mr0", 9'h000);
        @(negedge clk); inst("mr1", 9'h004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
